// File: rtl/scl_edge_monitor.sv
// I3C SCL/SDA receive front end: synchronizers, edge and START/STOP strobes,
// SCL phase measurement and bus-idle tracking. Optional macro: SCL_GLITCH_FILTER_EN.
module scl_edge_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int IDLE_CYCLES = 50
) (
   input  logic             i_clk_in,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_scl,
   input  logic             i_sda,
   output logic             o_scl_sync,
   output logic             o_sda_sync,
   output logic             o_scl_rise,
   output logic             o_scl_fall,
   output logic             o_start,
   output logic             o_stop,
   output logic             o_bus_idle,
   output logic [CNT_W-1:0] o_high_cnt,
   output logic [CNT_W-1:0] o_low_cnt,
   output logic             o_period_valid
);

   // state     | meaning
   // BUSY      | transfer in progress, waiting for STOP
   // FREE_WAIT | after STOP/reset/enable, counting cycles with both lines high
   // IDLE      | bus idle declared, o_bus_idle = 1
   typedef enum logic [1:0] {
      BUSY      = 2'd0,
      FREE_WAIT = 2'd1,
      IDLE      = 2'd2
   } state_t;

`ifdef SCL_GLITCH_FILTER_EN
   localparam int FILT_DLY = 1;
`else
   localparam int FILT_DLY = 0;
`endif
   localparam int               IW        = $clog2(IDLE_CYCLES + 1);
   localparam logic [IW-1:0]    IDLE_LAST = IW'(IDLE_CYCLES - 1);
   localparam logic [2:0]       FILL_DONE = 3'(SYNC_STAGES + FILT_DLY);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_v, sda_v;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic                   scl_rise_q, scl_rise_d;
   logic                   scl_fall_q, scl_fall_d;
   logic                   start_q, start_d;
   logic                   stop_q, stop_d;
   logic                   period_valid_q, period_valid_d;
   logic                   bus_idle_q, bus_idle_d;
   logic [CNT_W-1:0]       lvl_cnt_q, lvl_cnt_d;
   logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0]       low_cnt_q, low_cnt_d;
   logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
   logic [2:0]             fill_q, fill_d;
   logic                   seen_edge_q, seen_edge_d;
   logic                   low_ok_q, low_ok_d;
   state_t                 state_q, state_d;

   logic                   scl_rise, scl_fall, sda_rise, sda_fall;
   logic                   scl_stable_hi, start_det, stop_det, any_low;
   logic [CNT_W-1:0]       cnt_inc;

   assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
   assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};

`ifdef SCL_GLITCH_FILTER_EN
   logic scl_filt_q, scl_filt_d;
   logic sda_dly_q, sda_dly_d;

   // Filtered SCL follows only when the two newest sync samples agree.
   always_comb begin
      scl_filt_d = scl_filt_q;
      if (scl_sync_q[SYNC_STAGES-1] == scl_sync_q[SYNC_STAGES-2])
         scl_filt_d = scl_sync_q[SYNC_STAGES-1];
      sda_dly_d = sda_sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge i_clk_in or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scl_filt_q <= 1'b1;
         sda_dly_q  <= 1'b1;
      end else begin
         scl_filt_q <= scl_filt_d;
         sda_dly_q  <= sda_dly_d;
      end
   end

   assign scl_v = scl_filt_q;
   assign sda_v = sda_dly_q;
`else
   assign scl_v = scl_sync_q[SYNC_STAGES-1];
   assign sda_v = sda_sync_q[SYNC_STAGES-1];
`endif

   always_comb begin
      scl_rise      = scl_v & ~scl_prev_q;
      scl_fall      = ~scl_v & scl_prev_q;
      sda_rise      = sda_v & ~sda_prev_q;
      sda_fall      = ~sda_v & sda_prev_q;
      scl_stable_hi = scl_v & scl_prev_q;
      start_det     = sda_fall & scl_stable_hi;
      stop_det      = sda_rise & scl_stable_hi;
      any_low       = ~scl_v | ~sda_v;
      cnt_inc       = (lvl_cnt_q == CNT_MAX) ? CNT_MAX : lvl_cnt_q + 1'b1;

      // Reset values of the synchronizers are not real pad samples; wait them out.
      fill_d         = (fill_q == FILL_DONE) ? fill_q : fill_q + 3'd1;
      scl_prev_d     = scl_v;
      sda_prev_d     = sda_v;
      scl_rise_d     = 1'b0;
      scl_fall_d     = 1'b0;
      start_d        = 1'b0;
      stop_d         = 1'b0;
      period_valid_d = 1'b0;
      lvl_cnt_d      = lvl_cnt_q;
      high_cnt_d     = high_cnt_q;
      low_cnt_d      = low_cnt_q;
      idle_cnt_d     = idle_cnt_q;
      seen_edge_d    = seen_edge_q;
      low_ok_d       = low_ok_q;
      state_d        = state_q;

      if (!i_enable) begin
         lvl_cnt_d   = '0;
         idle_cnt_d  = '0;
         seen_edge_d = 1'b0;
         low_ok_d    = 1'b0;
         state_d     = FREE_WAIT;
      end else begin
         scl_rise_d = scl_rise;
         scl_fall_d = scl_fall;
         start_d    = start_det;
         stop_d     = stop_det;
         lvl_cnt_d  = (scl_rise | scl_fall) ? '0 : cnt_inc;

         if (scl_fall) begin
            high_cnt_d     = cnt_inc;
            period_valid_d = low_ok_q;
            seen_edge_d    = 1'b1;
         end
         // A rise after an earlier edge closes a fully observed low phase.
         if (scl_rise) begin
            low_cnt_d   = cnt_inc;
            seen_edge_d = 1'b1;
            if (seen_edge_q)
               low_ok_d = 1'b1;
         end

         unique case (state_q)
            BUSY: begin
               if (stop_det) begin
                  state_d    = FREE_WAIT;
                  idle_cnt_d = '0;
               end
            end
            FREE_WAIT: begin
               if (any_low) begin
                  state_d    = BUSY;
                  idle_cnt_d = '0;
               end else if (fill_q == FILL_DONE) begin
                  if (idle_cnt_q == IDLE_LAST)
                     state_d = IDLE;
                  else
                     idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
            IDLE: begin
               if (start_det || any_low) begin
                  state_d    = BUSY;
                  idle_cnt_d = '0;
               end
            end
            default: state_d = FREE_WAIT;
         endcase
      end

      bus_idle_d = (state_d == IDLE);
   end

   always_ff @(posedge i_clk_in or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scl_sync_q     <= '1;
         sda_sync_q     <= '1;
         scl_prev_q     <= 1'b1;
         sda_prev_q     <= 1'b1;
         scl_rise_q     <= 1'b0;
         scl_fall_q     <= 1'b0;
         start_q        <= 1'b0;
         stop_q         <= 1'b0;
         period_valid_q <= 1'b0;
         bus_idle_q     <= 1'b0;
         lvl_cnt_q      <= '0;
         high_cnt_q     <= '0;
         low_cnt_q      <= '0;
         idle_cnt_q     <= '0;
         fill_q         <= '0;
         seen_edge_q    <= 1'b0;
         low_ok_q       <= 1'b0;
         state_q        <= FREE_WAIT;
      end else begin
         scl_sync_q     <= scl_sync_d;
         sda_sync_q     <= sda_sync_d;
         scl_prev_q     <= scl_prev_d;
         sda_prev_q     <= sda_prev_d;
         scl_rise_q     <= scl_rise_d;
         scl_fall_q     <= scl_fall_d;
         start_q        <= start_d;
         stop_q         <= stop_d;
         period_valid_q <= period_valid_d;
         bus_idle_q     <= bus_idle_d;
         lvl_cnt_q      <= lvl_cnt_d;
         high_cnt_q     <= high_cnt_d;
         low_cnt_q      <= low_cnt_d;
         idle_cnt_q     <= idle_cnt_d;
         fill_q         <= fill_d;
         seen_edge_q    <= seen_edge_d;
         low_ok_q       <= low_ok_d;
         state_q        <= state_d;
      end
   end

   assign o_scl_sync     = scl_v;
   assign o_sda_sync     = sda_v;
   assign o_scl_rise     = scl_rise_q;
   assign o_scl_fall     = scl_fall_q;
   assign o_start        = start_q;
   assign o_stop         = stop_q;
   assign o_bus_idle     = bus_idle_q;
   assign o_high_cnt     = high_cnt_q;
   assign o_low_cnt      = low_cnt_q;
   assign o_period_valid = period_valid_q;

endmodule

// File: tb/tb_scl_edge_monitor.sv
// Directed self-checking bench for scl_edge_monitor (default parameters).
module tb_scl_edge_monitor;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 8;
   localparam int IDLE_CYCLES = 50;
`ifdef SCL_GLITCH_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif
   localparam int LAT = SYNC_STAGES + 1 + FILT;

   logic             i_clk_in = 1'b0;
   logic             i_rst_n;
   logic             i_enable;
   logic             i_scl;
   logic             i_sda;
   logic             o_scl_sync, o_sda_sync;
   logic             o_scl_rise, o_scl_fall, o_start, o_stop;
   logic             o_bus_idle, o_period_valid;
   logic [CNT_W-1:0] o_high_cnt, o_low_cnt;

   int tests = 0;
   int fails = 0;

   always #5 i_clk_in = ~i_clk_in;

   scl_edge_monitor #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W(CNT_W),
      .IDLE_CYCLES(IDLE_CYCLES)
   ) dut (
      .i_clk_in(i_clk_in),
      .i_rst_n(i_rst_n),
      .i_enable(i_enable),
      .i_scl(i_scl),
      .i_sda(i_sda),
      .o_scl_sync(o_scl_sync),
      .o_sda_sync(o_sda_sync),
      .o_scl_rise(o_scl_rise),
      .o_scl_fall(o_scl_fall),
      .o_start(o_start),
      .o_stop(o_stop),
      .o_bus_idle(o_bus_idle),
      .o_high_cnt(o_high_cnt),
      .o_low_cnt(o_low_cnt),
      .o_period_valid(o_period_valid)
   );

   task automatic tick();
      @(posedge i_clk_in);
      #1;
   endtask

   function automatic logic any_pulse();
      return o_scl_rise | o_scl_fall | o_start | o_stop | o_period_valid;
   endfunction

   // SCL pad pattern: high, then 4 periods of 5 low / 5 high, then low.
   function automatic logic clk_pat(int i);
      if (i < 2) return 1'b1;
      if (i >= 42) return 1'b0;
      return 1'(((i - 2) / 5) % 2);
   endfunction

   task automatic test_reset();
      int first_idle = 0;
      int pulses = 0;
      i_rst_n = 1'b0; i_enable = 1'b1; i_scl = 1'b1; i_sda = 1'b1;
      repeat (3) tick();
      tests++;
      if ({o_scl_sync, o_sda_sync, o_bus_idle} !== 3'b110) begin
         fails++; $display("FAIL reset_levels got %b want 110", {o_scl_sync, o_sda_sync, o_bus_idle});
      end
      tests++;
      if ({o_scl_rise, o_scl_fall, o_start, o_stop, o_period_valid} !== 5'b0) begin
         fails++; $display("FAIL reset_pulses got %b want 00000", {o_scl_rise, o_scl_fall, o_start, o_stop, o_period_valid});
      end
      tests++;
      if (o_high_cnt !== 8'd0 || o_low_cnt !== 8'd0) begin
         fails++; $display("FAIL reset_cnts got %0d/%0d want 0/0", o_high_cnt, o_low_cnt);
      end
      i_rst_n = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (o_bus_idle === 1'b1 && first_idle == 0) first_idle = k;
         if (any_pulse() !== 1'b0) pulses++;
      end
      tests++;
      if (first_idle != IDLE_CYCLES + SYNC_STAGES + FILT) begin
         fails++; $display("FAIL idle_latency got %0d want %0d", first_idle, IDLE_CYCLES + SYNC_STAGES + FILT);
      end
      tests++;
      if (pulses != 0) begin
         fails++; $display("FAIL idle_no_pulse got %0d want 0", pulses);
      end
   endtask

   task automatic test_start();
      int   start_k = 0;
      int   nstart = 0;
      logic idle_before = 1'b0;
      logic idle_at = 1'b1;
      i_sda = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (o_start === 1'b1) begin
            nstart++;
            if (start_k == 0) start_k = k;
         end
         if (k == LAT - 1) idle_before = o_bus_idle;
         if (k == LAT) idle_at = o_bus_idle;
      end
      tests++;
      if (nstart != 1 || start_k != LAT) begin
         fails++; $display("FAIL start_pulse got n=%0d at %0d want n=1 at %0d", nstart, start_k, LAT);
      end
      tests++;
      if (idle_before !== 1'b1 || idle_at !== 1'b0) begin
         fails++; $display("FAIL start_idle_drop got %b%b want 10", idle_before, idle_at);
      end
   endtask

   task automatic test_clocking();
      int   nrise = 0;
      int   nfall = 0;
      logic exp_r, exp_f;
      for (int k = 0; k <= 49 + LAT; k++) begin
         i_scl = clk_pat(k);
         tick();
         if (k >= LAT) begin
            exp_r = clk_pat(k - LAT + 1) & ~clk_pat(k - LAT);
            exp_f = ~clk_pat(k - LAT + 1) & clk_pat(k - LAT);
            tests++;
            if ({o_scl_rise, o_scl_fall} !== {exp_r, exp_f}) begin
               fails++; $display("FAIL edge_strobe k=%0d got %b%b want %b%b", k, o_scl_rise, o_scl_fall, exp_r, exp_f);
            end
         end
         if (o_start !== 1'b0 || o_stop !== 1'b0) begin
            tests++; fails++; $display("FAIL clk_no_startstop k=%0d got %b%b want 00", k, o_start, o_stop);
         end
         if (o_scl_rise === 1'b1) begin
            nrise++;
            tests++;
            if (o_low_cnt !== 8'd5) begin
               fails++; $display("FAIL low_cnt got %0d want 5", o_low_cnt);
            end
         end
         if (o_scl_fall === 1'b1) begin
            nfall++;
            tests++;
            if (nfall == 1) begin
               if (o_period_valid !== 1'b0) begin
                  fails++; $display("FAIL first_period_valid got %b want 0", o_period_valid);
               end
            end else if (o_period_valid !== 1'b1 || o_high_cnt !== 8'd5 || o_low_cnt !== 8'd5) begin
               fails++; $display("FAIL period fall=%0d got v=%b h=%0d l=%0d want v=1 h=5 l=5", nfall, o_period_valid, o_high_cnt, o_low_cnt);
            end
         end
      end
      tests++;
      if (nrise != 4 || nfall != 5) begin
         fails++; $display("FAIL clk_edge_count got r=%0d f=%0d want r=4 f=5", nrise, nfall);
      end
   endtask

   task automatic test_saturation();
      int               fall_k = 0;
      logic [CNT_W-1:0] hi = '0;
      logic [CNT_W-1:0] lo = '0;
      i_scl = 1'b1;
      repeat (300) tick();
      i_scl = 1'b0;
      for (int k = 1; k <= LAT + 3; k++) begin
         tick();
         if (o_scl_fall === 1'b1 && fall_k == 0) begin
            fall_k = k; hi = o_high_cnt; lo = o_low_cnt;
         end
      end
      tests++;
      if (fall_k != LAT || hi !== 8'd255) begin
         fails++; $display("FAIL high_saturate got at=%0d h=%0d want at=%0d h=255", fall_k, hi, LAT);
      end
      tests++;
      if (lo !== 8'(8 + LAT)) begin
         fails++; $display("FAIL tail_low_cnt got %0d want %0d", lo, 8 + LAT);
      end
   endtask

   task automatic test_same_cycle();
      int nr = 0;
      int nf = 0;
      int nss = 0;
      i_scl = 1'b1; i_sda = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (o_scl_rise === 1'b1) nr++;
         if (o_start === 1'b1 || o_stop === 1'b1) nss++;
      end
      i_scl = 1'b0; i_sda = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (o_scl_fall === 1'b1) nf++;
         if (o_start === 1'b1 || o_stop === 1'b1) nss++;
      end
      tests++;
      if (nr != 1 || nf != 1) begin
         fails++; $display("FAIL same_cycle_edges got r=%0d f=%0d want 1/1", nr, nf);
      end
      tests++;
      if (nss != 0) begin
         fails++; $display("FAIL same_cycle_startstop got %0d want 0", nss);
      end
   endtask

   task automatic test_stop_then_low();
      int nstop = 0;
      int stop_k = 0;
      int nstart = 0;
      int idle_seen = 0;
      i_scl = 1'b1;
      repeat (5) tick();
      i_sda = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (o_stop === 1'b1) begin
            nstop++;
            if (stop_k == 0) stop_k = k;
         end
         if (o_bus_idle !== 1'b0) idle_seen++;
      end
      i_sda = 1'b0;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (o_start === 1'b1) nstart++;
         if (o_bus_idle !== 1'b0) idle_seen++;
      end
      tests++;
      if (nstop != 1 || stop_k != LAT) begin
         fails++; $display("FAIL stop_pulse got n=%0d at %0d want n=1 at %0d", nstop, stop_k, LAT);
      end
      tests++;
      if (nstart != 1) begin
         fails++; $display("FAIL restart_pulse got %0d want 1", nstart);
      end
      tests++;
      if (idle_seen != 0) begin
         fails++; $display("FAIL no_idle_after_stop got %0d want 0", idle_seen);
      end
   endtask

   task automatic test_enable_toggle();
      int nvalid = 0;
      int pulses = 0;
      int nfall = 0;
      logic v1 = 1'b1;
      logic v2 = 1'b0;
      logic [CNT_W-1:0] h2 = '0;
      logic [CNT_W-1:0] l2 = '0;
      i_scl = 1'b0; repeat (7) tick();
      i_scl = 1'b1; repeat (6) tick();
      i_scl = 1'b0; repeat (LAT + 2) tick();
      tests++;
      if (o_high_cnt !== 8'd6 || o_low_cnt !== 8'd7) begin
         fails++; $display("FAIL pre_disable_cnts got h=%0d l=%0d want 6/7", o_high_cnt, o_low_cnt);
      end
      i_enable = 1'b0;
      for (int k = 0; k < 20; k++) begin
         i_scl = 1'((k / 3) % 2);
         tick();
         if (any_pulse() !== 1'b0) pulses++;
      end
      i_scl = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (any_pulse() !== 1'b0) pulses++;
      end
      tests++;
      if (o_high_cnt !== 8'd6 || o_low_cnt !== 8'd7 || o_bus_idle !== 1'b0) begin
         fails++; $display("FAIL disabled_hold got h=%0d l=%0d idle=%b want 6/7/0", o_high_cnt, o_low_cnt, o_bus_idle);
      end
      i_enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (any_pulse() !== 1'b0) pulses++;
      end
      tests++;
      if (pulses != 0) begin
         fails++; $display("FAIL enable_spurious got %0d want 0", pulses);
      end
      for (int k = 0; k < 9 + LAT + 3; k++) begin
         i_scl = (k < 5) ? 1'b0 : (k < 9) ? 1'b1 : 1'b0;
         tick();
         if (o_period_valid === 1'b1) nvalid++;
         if (o_scl_fall === 1'b1) begin
            nfall++;
            if (nfall == 1) v1 = o_period_valid;
            if (nfall == 2) begin v2 = o_period_valid; h2 = o_high_cnt; l2 = o_low_cnt; end
         end
      end
      tests++;
      if (nfall != 2 || v1 !== 1'b0 || v2 !== 1'b1 || nvalid != 1) begin
         fails++; $display("FAIL reenable_qual got f=%0d v=%b%b n=%0d want f=2 v=01 n=1", nfall, v1, v2, nvalid);
      end
      tests++;
      if (h2 !== 8'd4 || l2 !== 8'd5) begin
         fails++; $display("FAIL reenable_cnts got h=%0d l=%0d want 4/5", h2, l2);
      end
   endtask

`ifdef SCL_GLITCH_FILTER_EN
   task automatic test_glitch();
      int nf = 0;
      int fall_k = 0;
      i_scl = 1'b1; repeat (8) tick();
      i_scl = 1'b0; tick();
      i_scl = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (o_scl_fall === 1'b1 || o_scl_rise === 1'b1) nf++;
      end
      tests++;
      if (nf != 0) begin
         fails++; $display("FAIL glitch_suppress got %0d want 0", nf);
      end
      for (int k = 1; k <= 10; k++) begin
         i_scl = (k <= 3) ? 1'b0 : 1'b1;
         tick();
         if (o_scl_fall === 1'b1 && fall_k == 0) fall_k = k;
      end
      tests++;
      if (fall_k != LAT) begin
         fails++; $display("FAIL filter_latency got %0d want %0d", fall_k, LAT);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_start();
      test_clocking();
      test_saturation();
      test_same_cycle();
      test_stop_then_low();
      test_enable_toggle();
`ifdef SCL_GLITCH_FILTER_EN
      test_glitch();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
